// File: rtl/fb_sync_pkg.sv
// Shared types and sizing helpers for the synchronise-and-debounce block.
package fb_sync_pkg;

  typedef enum logic [0:0] {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } fsm_state_t;

  // Bits needed to hold any value in 0..max_count.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/fb_sync_debounce_if.sv
// Signal bundle for fb_sync_debounce: raw inputs and filter control in, debounced level/edges out.
interface fb_sync_debounce_if #(
  parameter int unsigned NUM_BITS = 1
);
  logic [NUM_BITS-1:0] sync_in;
  logic                filt_en;
  logic [NUM_BITS-1:0] level_out;
  logic [NUM_BITS-1:0] rise_pulse;
  logic [NUM_BITS-1:0] fall_pulse;
  logic [NUM_BITS-1:0] pending;

  modport master (
    output sync_in, filt_en,
    input  level_out, rise_pulse, fall_pulse, pending
  );

  modport slave (
    input  sync_in, filt_en,
    output level_out, rise_pulse, fall_pulse, pending
  );
endinterface

// File: rtl/fb_bit_sync.sv
// Multi-flop synchroniser for NUM_BITS independent asynchronous inputs.
module fb_bit_sync #(
  parameter int unsigned NUM_BITS = 1,
  parameter int unsigned STAGE    = 2,
  parameter int unsigned EDGE     = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_BITS-1:0] d,
  output logic [NUM_BITS-1:0] q
);

  logic [STAGE-1:0][NUM_BITS-1:0] sync_q;
  logic [STAGE-1:0][NUM_BITS-1:0] sync_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d;
    for (int unsigned i = 1; i < STAGE; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // EDGE selects the sampling edge; 1 = posedge.
  generate
    if (EDGE != 0) begin : g_pos
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= sync_d;
      end
    end else begin : g_neg
      always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= sync_d;
      end
    end
  endgenerate

  assign q = sync_q[STAGE-1];

endmodule

// File: rtl/fb_sync_debounce.sv
// Synchronises raw inputs, then accepts a level change only after DEBOUNCE_CYCLES stable cycles.
module fb_sync_debounce
  import fb_sync_pkg::*;
#(
  parameter int unsigned         NUM_BITS        = 1,
  parameter int unsigned         STAGE           = 2,
  parameter int unsigned         DEBOUNCE_CYCLES = 4,
  parameter logic [NUM_BITS-1:0] RESET_VAL       = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_BITS-1:0] sync_in,
  input  logic                filt_en,
  output logic [NUM_BITS-1:0] level_out,
  output logic [NUM_BITS-1:0] rise_pulse,
  output logic [NUM_BITS-1:0] fall_pulse,
  output logic [NUM_BITS-1:0] pending
);

  localparam int unsigned       CNT_W     = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned       WARM_W    = cnt_width(STAGE);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(STAGE - 1);

  logic [NUM_BITS-1:0] s;

  fsm_state_t                      state_q, state_d;
  logic [WARM_W-1:0]               warm_q, warm_d;
  logic [NUM_BITS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_BITS-1:0]             level_q, level_d;
  logic [NUM_BITS-1:0]             rise_q, rise_d;
  logic [NUM_BITS-1:0]             fall_q, fall_d;
  logic [NUM_BITS-1:0]             pend_q, pend_d;

  fb_bit_sync #(
    .NUM_BITS (NUM_BITS),
    .STAGE    (STAGE),
    .EDGE     (1)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sync_in),
    .q       (s)
  );

  // Warm-up lets reset zeros drain out of the synchroniser before filtering.
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    if (state_q == WARMUP) begin
      if (warm_q == WARM_LAST) begin
        state_d = RUN;
        warm_d  = '0;
      end else begin
        warm_d = warm_q + 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    pend_d  = '0;
    if (state_q == WARMUP) begin
      cnt_d   = '0;
      level_d = RESET_VAL;
    end else begin
      for (int unsigned i = 0; i < NUM_BITS; i++) begin
        if (!filt_en) begin
          cnt_d[i]   = '0;
          level_d[i] = s[i];
        end else if (s[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]   = '0;
          level_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    for (int unsigned i = 0; i < NUM_BITS; i++) begin
      pend_d[i] = (cnt_d[i] != '0);
    end
    // Edges derived from the registered level, so pulses coincide with the change.
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WARMUP;
      warm_q  <= '0;
      cnt_q   <= '0;
      level_q <= RESET_VAL;
      rise_q  <= '0;
      fall_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pend_q  <= pend_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign pending    = pend_q;

endmodule

// File: tb/tb_fb_sync_debounce.sv
// Bench for fb_sync_debounce: directed scenarios plus random stimulus against a window-based reference model.
module tb_fb_sync_debounce;

  localparam int unsigned NB = 2;
  localparam int unsigned ST = 2;
  localparam int unsigned DC = 4;
  localparam logic [NB-1:0] RV0 = 2'b00;
  localparam logic [NB-1:0] RV1 = 2'b11;

  typedef struct packed {
    logic [NB-1:0] level;
    logic [NB-1:0] rise;
    logic [NB-1:0] fall;
    logic [NB-1:0] pend;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fb_sync_debounce_if #(.NUM_BITS(NB)) bus0 ();
  fb_sync_debounce_if #(.NUM_BITS(NB)) bus1 ();

  fb_sync_debounce #(
    .NUM_BITS(NB), .STAGE(ST), .DEBOUNCE_CYCLES(DC), .RESET_VAL(RV0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .sync_in(bus0.sync_in), .filt_en(bus0.filt_en),
    .level_out(bus0.level_out), .rise_pulse(bus0.rise_pulse),
    .fall_pulse(bus0.fall_pulse), .pending(bus0.pending)
  );

  fb_sync_debounce #(
    .NUM_BITS(NB), .STAGE(ST), .DEBOUNCE_CYCLES(DC), .RESET_VAL(RV1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .sync_in(bus1.sync_in), .filt_en(bus1.filt_en),
    .level_out(bus1.level_out), .rise_pulse(bus1.rise_pulse),
    .fall_pulse(bus1.fall_pulse), .pending(bus1.pending)
  );

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a change is accepted once DC consecutive qualifying mismatches
  // have been seen since the last acceptance; s lags the sampled input by ST edges.
  logic [NB-1:0] lvl_m = RV0;
  int unsigned   e_m = 0;
  logic [NB-1:0] in_hist[$];
  bit            ok_hist [NB][DC];

  always @(posedge clk) begin
    exp_t x;
    bit   run, q_en, mism, acc, win;
    logic s_b;
    x = '0;
    if (!reset_n) begin
      lvl_m = RV0;
      e_m   = 0;
      in_hist.delete();
      for (int b = 0; b < NB; b++)
        for (int j = 0; j < DC; j++) ok_hist[b][j] = 1'b0;
    end else begin
      e_m++;
      in_hist.push_back(bus0.sync_in);
      run = (e_m > ST);
      for (int b = 0; b < NB; b++) begin
        s_b  = run ? in_hist[e_m - 1 - ST][b] : 1'b0;
        mism = (s_b != lvl_m[b]);
        q_en = run && bus0.filt_en;
        acc  = 1'b0;
        if (run && !bus0.filt_en) begin
          if (mism) begin
            x.rise[b] = s_b;
            x.fall[b] = !s_b;
          end
          lvl_m[b] = s_b;
        end else if (q_en && mism) begin
          win = 1'b1;
          for (int j = 0; j < DC - 1; j++) win = win && ok_hist[b][j];
          if (win) begin
            acc       = 1'b1;
            x.rise[b] = s_b;
            x.fall[b] = !s_b;
            lvl_m[b]  = s_b;
          end
        end
        x.pend[b] = q_en && mism && !acc;
        for (int j = DC - 1; j > 0; j--) ok_hist[b][j] = ok_hist[b][j-1];
        ok_hist[b][0] = x.pend[b];
      end
    end
    x.level = lvl_m;
    exp_q.push_back(x);
  end

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty: got no expected entry at %0t", $time);
    end else begin
      x = exp_q.pop_front();
      chk("sb_level", bus0.level_out, x.level);
      chk("sb_rise", bus0.rise_pulse, x.rise);
      chk("sb_fall", bus0.fall_pulse, x.fall);
      chk("sb_pending", bus0.pending, x.pend);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int rc, fc, hold0, hold1;
    logic [NB-1:0] v;
    bus0.sync_in = '0;
    bus0.filt_en = 1'b1;
    bus1.sync_in = '0;
    bus1.filt_en = 1'b1;
    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;

    // Edges 1..9: dut1 idles through warm-up, then drops both bits together.
    for (int e = 1; e <= 9; e++) begin
      step(1);
      chk("rv_level", bus1.level_out, (e >= 6) ? 2'b00 : 2'b11);
      chk("rv_fall", bus1.fall_pulse, (e == 6) ? 2'b11 : 2'b00);
      chk("rv_pending", bus1.pending, (e >= 3 && e <= 5) ? 2'b11 : 2'b00);
    end

    bus0.sync_in[0] = 1'b1;
    for (int e = 10; e <= 16; e++) begin
      step(1);
      chk("rise_pending", {1'b0, bus0.pending[0]}, {1'b0, (e >= 12 && e <= 14)});
      chk("rise_level", {1'b0, bus0.level_out[0]}, {1'b0, (e >= 15)});
      chk("rise_pulse", {1'b0, bus0.rise_pulse[0]}, {1'b0, (e == 15)});
    end

    bus0.sync_in[0] = 1'b0;
    step(3);
    bus0.sync_in[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("glitch_level", {1'b0, bus0.level_out[0]}, 2'b01);
      chk("glitch_fall", {1'b0, bus0.fall_pulse[0]}, 2'b00);
    end
    chk("glitch_pending", {1'b0, bus0.pending[0]}, 2'b00);

    bus0.sync_in = 2'b10;
    step(5);
    chk("opp_rise_early", bus0.rise_pulse, 2'b00);
    step(1);
    chk("opp_rise", bus0.rise_pulse, 2'b10);
    chk("opp_fall", bus0.fall_pulse, 2'b01);

    bus0.filt_en = 1'b0;
    bus0.sync_in[1] = 1'b0;
    step(4);
    rc = 0;
    fc = 0;
    repeat (3) begin
      bus0.sync_in[1] = 1'b1;
      step(1);
      rc += int'(bus0.rise_pulse[1]);
      fc += int'(bus0.fall_pulse[1]);
      bus0.sync_in[1] = 1'b0;
      repeat (2) begin
        step(1);
        rc += int'(bus0.rise_pulse[1]);
        fc += int'(bus0.fall_pulse[1]);
      end
    end
    repeat (3) begin
      step(1);
      rc += int'(bus0.rise_pulse[1]);
      fc += int'(bus0.fall_pulse[1]);
    end
    chk("bypass_rises", 2'(rc), 2'd3);
    chk("bypass_falls", 2'(fc), 2'd3);

    bus0.filt_en = 1'b1;
    step(2);
    bus0.sync_in[0] = 1'b1;
    step(4);
    chk("abort_pending_pre", bus0.pending, 2'b01);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_level", bus0.level_out, RV0);
    chk("abort_pending", bus0.pending, 2'b00);
    chk("abort_rise", bus0.rise_pulse, 2'b00);
    chk("abort_rv_level", bus1.level_out, RV1);
    step(2);
    reset_n = 1'b1;
    step(2);
    chk("rewarm_pending", bus0.pending, 2'b00);
    chk("rewarm_rv_level", bus1.level_out, RV1);
    step(1);
    chk("rewarm_run_pending", bus0.pending, 2'b01);

    // Random phase: held values of random length, occasional filter toggles and resets.
    hold0 = 0;
    hold1 = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(199) == 0) begin
        reset_n = 1'b0;
        #1;
        chk("rnd_async_level", bus0.level_out, RV0);
        chk("rnd_async_pending", bus0.pending, 2'b00);
        step($urandom_range(3, 1));
        reset_n = 1'b1;
      end
      if ($urandom_range(39) == 0) bus0.filt_en = ~bus0.filt_en;
      v = bus0.sync_in;
      if (hold0 == 0) begin
        v[0] = 1'($urandom_range(1));
        hold0 = $urandom_range(8, 1);
      end
      if (hold1 == 0) begin
        v[1] = 1'($urandom_range(1));
        hold1 = $urandom_range(8, 1);
      end
      hold0--;
      hold1--;
      bus0.sync_in = v;
      step(1);
    end

    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
